// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for prog_loader.
// master = stream source / system side, slave = the loader.
interface prog_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              core_rst;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  core_rst, done, error, words_loaded
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        output core_rst, done, error, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Byte-serial program loader: frames N (16-bit LE) + N little-endian words into instruction memory.
// Optional LOADER_CHECKSUM_EN adds an XOR trailer byte checked before releasing the core.
module prog_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 80,
    parameter int ADDR_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  lif
);
    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state_r;
    logic [15:0]       n_r;
    logic [DATA_W-9:0] word_r;
    logic [1:0]        byte_cnt_r;
    logic [15:0]       words_loaded_r;
    logic              mem_wr_en_r;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [DATA_W-1:0] mem_wr_data_r;
    logic              core_rst_r;
    logic              done_r;
    logic              error_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    logic              ready_s;
    logic              accept_s;
    logic [15:0]       n_full_s;
    logic [DATA_W-1:0] word_next_s;
    logic              more_s;

    assign accept_s    = lif.byte_valid && lif.byte_ready;
    assign n_full_s    = {lif.byte_in, n_r[7:0]};
    assign word_next_s = {lif.byte_in, word_r};
    assign more_s      = ({1'b0, words_loaded_r} + 17'd1) < {1'b0, n_r};

    // Ready decode from the state register; held low while reset is asserted.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            S_HDR0, S_HDR1, S_DATA: ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                  ready_s = 1'b1;
`endif
            default:                ready_s = 1'b0;
        endcase
    end

    assign lif.byte_ready   = ready_s && !rst;
    assign lif.mem_wr_en    = mem_wr_en_r;
    assign lif.mem_wr_addr  = mem_wr_addr_r;
    assign lif.mem_wr_data  = mem_wr_data_r;
    assign lif.core_rst     = core_rst_r;
    assign lif.done         = done_r;
    assign lif.error        = error_r;
    assign lif.words_loaded = words_loaded_r;

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_HDR0;
            n_r            <= 16'd0;
            word_r         <= '0;
            byte_cnt_r     <= 2'd0;
            words_loaded_r <= 16'd0;
            mem_wr_en_r    <= 1'b0;
            mem_wr_addr_r  <= '0;
            mem_wr_data_r  <= '0;
            core_rst_r     <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_r         <= 8'h00;
`endif
        end else begin
            case (state_r)
                S_HDR0: begin
                    if (accept_s) begin
                        n_r[7:0] <= lif.byte_in;
                        state_r  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept_s) begin
                        n_r[15:8]      <= lif.byte_in;
                        byte_cnt_r     <= 2'd0;
                        words_loaded_r <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_r         <= 8'h00;
`endif
                        if (n_full_s > DEPTH_W) begin
                            state_r <= S_ERR;
                            error_r <= 1'b1;
                        end else if (n_full_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_r    <= S_CHK;
`else
                            state_r    <= S_DONE;
                            done_r     <= 1'b1;
                            core_rst_r <= 1'b0;
`endif
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        word_r     <= word_next_s[DATA_W-1:8];
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_r     <= csum_r ^ lif.byte_in;
`endif
                        if (byte_cnt_r == 2'd3) begin
                            state_r       <= S_WRITE;
                            mem_wr_en_r   <= 1'b1;
                            mem_wr_addr_r <= {{(ADDR_W-16){1'b0}}, words_loaded_r};
                            mem_wr_data_r <= word_next_s;
                        end
                    end
                end
                S_WRITE: begin
                    mem_wr_en_r    <= 1'b0;
                    words_loaded_r <= words_loaded_r + 16'd1;
                    if (more_s) begin
                        state_r <= S_DATA;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_r    <= S_CHK;
`else
                        state_r    <= S_DONE;
                        done_r     <= 1'b1;
                        core_rst_r <= 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept_s) begin
                        if (lif.byte_in == csum_r) begin
                            state_r    <= S_DONE;
                            done_r     <= 1'b1;
                            core_rst_r <= 1'b0;
                        end else begin
                            state_r <= S_ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (lif.start) begin
                        state_r        <= S_HDR0;
                        core_rst_r     <= 1'b1;
                        done_r         <= 1'b0;
                        error_r        <= 1'b0;
                        words_loaded_r <= 16'd0;
                    end
                end
                default: begin
                    state_r     <= S_HDR0;
                    mem_wr_en_r <= 1'b0;
                    core_rst_r  <= 1'b1;
                    done_r      <= 1'b0;
                    error_r     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized loads against a queue model.
// Follows LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] words_q[$];

    always #5 clk = ~clk;

    prog_loader_if lif ();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .lif (lif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Capture every write strobe; the loader must never be ready during a write.
    always @(negedge clk) begin
        if (lif.mem_wr_en === 1'b1) begin
            obs_addr.push_back(lif.mem_wr_addr);
            obs_data.push_back(lif.mem_wr_data);
            check("ready_in_write", {63'd0, lif.byte_ready}, 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        lif.byte_in    = b;
        lif.byte_valid = 1'b1;
        t = 0;
        while (lif.byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("ready_timeout", {63'd0, lif.byte_ready}, 64'd1);
            lif.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 lif.byte_valid = 1'b0;
        end
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Send a frame built from words_q and compare against the expected writes and final state.
    task automatic run_load(input int n, input int gmin, input int gmax, input bit bad_trailer);
        logic [7:0]  csum;
        logic [15:0] nn;
        logic [31:0] w;
        bit          ok;
        int          nexp;
        int          t;
        nn = 16'(n);
        csum = 8'h00;
        obs_addr.delete();
        obs_data.delete();
        send_byte(nn[7:0], $urandom_range(gmax, gmin));
        send_byte(nn[15:8], $urandom_range(gmax, gmin));
        nexp = (n <= 80) ? n : 0;
        for (int i = 0; i < nexp; i++) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], $urandom_range(gmax, gmin));
                csum = csum ^ w[8*k +: 8];
            end
        end
        ok = (n <= 80);
`ifdef LOADER_CHECKSUM_EN
        if (n <= 80) begin
            send_byte(bad_trailer ? (csum ^ 8'h01) : csum, $urandom_range(gmax, gmin));
            ok = !bad_trailer;
        end
`endif
        t = 0;
        while (lif.done !== 1'b1 && lif.error !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("done", {63'd0, lif.done}, {63'd0, ok});
        check("error", {63'd0, lif.error}, {63'd0, !ok});
        check("core_rst", {63'd0, lif.core_rst}, {63'd0, !ok});
        check("ready_final", {63'd0, lif.byte_ready}, 64'd0);
        check("words_loaded", {48'd0, lif.words_loaded}, 64'(nexp));
        check("write_count", 64'(obs_addr.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < obs_addr.size(); i++) begin
            check($sformatf("addr[%0d]", i), obs_addr[i], 64'(i));
            check($sformatf("data[%0d]", i), {32'd0, obs_data[i]}, {32'd0, words_q[i]});
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        lif.start = 1'b1;
        @(posedge clk);
        #1 lif.start = 1'b0;
        @(negedge clk);
        check("rearm_core_rst", {63'd0, lif.core_rst}, 64'd1);
        check("rearm_done", {63'd0, lif.done}, 64'd0);
        check("rearm_error", {63'd0, lif.error}, 64'd0);
        check("rearm_words", {48'd0, lif.words_loaded}, 64'd0);
        check("rearm_ready", {63'd0, lif.byte_ready}, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {63'd0, lif.byte_ready}, 64'd0);
        check({tag, "_core_rst"}, {63'd0, lif.core_rst}, 64'd1);
        check({tag, "_wr_en"}, {63'd0, lif.mem_wr_en}, 64'd0);
        check({tag, "_done"}, {63'd0, lif.done}, 64'd0);
        check({tag, "_error"}, {63'd0, lif.error}, 64'd0);
        check({tag, "_words"}, {48'd0, lif.words_loaded}, 64'd0);
        check({tag, "_addr"}, lif.mem_wr_addr, 64'd0);
        check({tag, "_data"}, {32'd0, lif.mem_wr_data}, 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        lif.start      = 1'b0;
        lif.byte_in    = 8'h00;
        lif.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("hdr0_ready", {63'd0, lif.byte_ready}, 64'd1);

        // Basic two-word program, continuous stream then toggling valid.
        words_q = '{32'h00500093, 32'h00A00113};
        run_load(2, 0, 0, 1'b0);
        rearm();
        run_load(2, 1, 1, 1'b0);
        rearm();

        // Oversized header aborts without writes.
        run_load(81, 0, 0, 1'b0);
        rearm();

        // Empty image.
        words_q.delete();
        run_load(0, 0, 0, 1'b0);
        rearm();
`ifdef LOADER_CHECKSUM_EN
        run_load(0, 0, 0, 1'b1);
        rearm();
        words_q = '{32'h11223344};
        run_load(1, 0, 0, 1'b0);
        rearm();
        run_load(1, 0, 0, 1'b1);
        rearm();
`endif

        // Reset in the middle of the second word.
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        fill_random(1);
        run_load(1, 0, 0, 1'b0);

        // Restart from DONE and load again.
        rearm();
        fill_random(1);
        run_load(1, 0, 1, 1'b0);

        // Randomized loads with random gaps, then the full-depth boundary.
        for (int r = 0; r < 8; r++) begin
            rearm();
            fill_random($urandom_range(12, 1));
            run_load(words_q.size(), 0, 2, 1'b0);
        end
        rearm();
        fill_random(80);
        run_load(80, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
